// File: rtl/dot_prod_peak_if.sv
// Stream bundle for dot_prod_peak: I/Q dot-product results in, peak result out.
//
// Handshake: a transfer happens on a rising clock edge where the sender's
// tvalid and the receiver's tready are both 1. A valid seen while ready is
// low is dropped, not queued. Once the peak side raises s_axis_peak_tvalid,
// peak_index/peak_mag stay stable until the edge where m_axis_peak_tready is 1.
interface dot_prod_peak_if #(
   parameter int i_bits     = 24,
   parameter int q_bits     = 24,
   parameter int index_bits = 3,
   parameter int mag_bits   = i_bits + q_bits
);
   logic                         m_axis_product_tvalid;
   logic signed [i_bits-1:0]     i;
   logic signed [q_bits-1:0]     q;
   logic                         s_axis_product_tready;
   logic                         m_axis_peak_tready;
   logic                         s_axis_peak_tvalid;
   logic        [index_bits-1:0] peak_index;
   logic        [mag_bits-1:0]   peak_mag;

   // Upstream producer / downstream consumer side
   modport master (
      output m_axis_product_tvalid, i, q, m_axis_peak_tready,
      input  s_axis_product_tready, s_axis_peak_tvalid, peak_index, peak_mag
   );

   // Peak-search block side
   modport slave (
      input  m_axis_product_tvalid, i, q, m_axis_peak_tready,
      output s_axis_product_tready, s_axis_peak_tvalid, peak_index, peak_mag
   );
endinterface

// File: rtl/dot_prod_peak.sv
// Peak search over frames of complex dot-product results: for each frame of
// `length` accepted samples, reports the position and i^2+q^2 of the largest
// magnitude (earliest wins on ties). Three-stage pipeline: square, sum, compare.
module dot_prod_peak #(
   parameter int i_bits     = 24,
   parameter int q_bits     = 24,
   parameter int length     = 8,
   parameter int index_bits = 3,
   parameter int mag_bits   = i_bits + q_bits
) (
   input  logic       clk,
   input  logic       rst_n,
   dot_prod_peak_if.slave bus,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FLUSH = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                  rdy_en_q;      // low until the first edge after reset release
   logic [index_bits-1:0] cnt_q, cnt_d;  // acceptance position within the frame

   logic                  product_tready;
   logic                  accept;
   logic                  last_accept;
   logic                  handoff;

   // Stage 1: squares
   logic                  v1_q, first1_q;
   logic [index_bits-1:0] idx1_q;
   logic [mag_bits-1:0]   sqi_q, sqq_q;
   // Stage 2: magnitude
   logic                  v2_q, first2_q;
   logic [index_bits-1:0] idx2_q;
   logic [mag_bits-1:0]   mag_q;
   // Stage 3: best so far
   logic [mag_bits-1:0]   best_mag_q;
   logic [index_bits-1:0] best_idx_q;

   // Squares are formed on sign-extended operands; the low 2N bits of an
   // unsigned product equal the signed product, and a square is never negative.
   logic [2*i_bits-1:0] i_ext, sq_i_w;
   logic [2*q_bits-1:0] q_ext, sq_q_w;

   assign i_ext  = {{i_bits{bus.i[i_bits-1]}}, bus.i};
   assign q_ext  = {{q_bits{bus.q[q_bits-1]}}, bus.q};
   assign sq_i_w = i_ext * i_ext;
   assign sq_q_w = q_ext * q_ext;

   assign accept      = product_tready && bus.m_axis_product_tvalid;
   assign last_accept = accept && (cnt_q == index_bits'(length - 1));
   assign handoff     = (state_q == OUT) && bus.m_axis_peak_tready;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // FSM next state: FLUSH drains until both pipeline stages ahead of the compare are empty
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (last_accept)     state_d = FLUSH;
         FLUSH:   if (!v1_q && !v2_q)  state_d = OUT;
         OUT:     if (handoff)         state_d = ACCUM;
         default:                      state_d = ACCUM;
      endcase
   end

   // FSM outputs: ready only while collecting, peak valid only while presenting
   always_comb begin
      product_tready            = (state_q == ACCUM) && rdy_en_q;
      bus.s_axis_product_tready = product_tready;
      bus.s_axis_peak_tvalid    = (state_q == OUT);
      bus.peak_index            = best_idx_q;
      bus.peak_mag              = best_mag_q;
      dbg_state_o               = state_q;
   end

   // Hold off accepting until one edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en_q <= 1'b0;
      else        rdy_en_q <= 1'b1;
   end

   // Acceptance counter next value: wraps on the last sample, cleared on handoff
   always_comb begin
      cnt_d = cnt_q;
      if (handoff)          cnt_d = '0;
      else if (last_accept) cnt_d = '0;
      else if (accept)      cnt_d = cnt_q + index_bits'(1);
   end

   // Acceptance counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Stage 1: register squares with frame position and first-of-frame flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         idx1_q   <= '0;
         sqi_q    <= '0;
         sqq_q    <= '0;
      end else begin
         v1_q <= accept;
         if (accept) begin
            first1_q <= (cnt_q == '0);
            idx1_q   <= cnt_q;
            sqi_q    <= mag_bits'(sq_i_w);
            sqq_q    <= mag_bits'(sq_q_w);
         end
      end
   end

   // Stage 2: register the magnitude squared (exact, cannot overflow mag_bits)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q     <= 1'b0;
         first2_q <= 1'b0;
         idx2_q   <= '0;
         mag_q    <= '0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            first2_q <= first1_q;
            idx2_q   <= idx1_q;
            mag_q    <= sqi_q + sqq_q;
         end
      end
   end

   // Stage 3: first sample loads unconditionally, later ones only if strictly larger
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_mag_q <= '0;
         best_idx_q <= '0;
      end else if (handoff) begin
         best_mag_q <= '0;
         best_idx_q <= '0;
      end else if (v2_q && (first2_q || (mag_q > best_mag_q))) begin
         best_mag_q <= mag_q;
         best_idx_q <= idx2_q;
      end
   end

endmodule

// File: tb/tb_dot_prod_peak.sv
// Directed bench for dot_prod_peak with length=4, 8-bit I/Q, 16-bit magnitude.
module tb_dot_prod_peak;

   localparam int IB  = 8;
   localparam int LEN = 4;
   localparam int XB  = 2;
   localparam int MB  = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Clock
   always #5 clk = ~clk;

   dot_prod_peak_if #(.i_bits(IB), .q_bits(IB), .index_bits(XB), .mag_bits(MB)) bus ();

   dot_prod_peak #(
      .i_bits(IB), .q_bits(IB), .length(LEN), .index_bits(XB), .mag_bits(MB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .dbg_state_o(dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for one edge, then idle for `gap` cycles
   task automatic send(input int si, input int sq, input int gap);
      bus.i = IB'(si);
      bus.q = IB'(sq);
      bus.m_axis_product_tvalid = 1'b1;
      check("ready_before_accept", 32'(bus.s_axis_product_tready), 1);
      tick();
      bus.m_axis_product_tvalid = 1'b0;
      repeat (gap) tick();
   endtask

   // Called just after the last accepting edge; expects tvalid exactly 3 edges later
   task automatic expect_peak(input string tag, input int exp_idx, input int exp_mag);
      int n;
      n = 0;
      while (bus.s_axis_peak_tvalid !== 1'b1 && n < 20) begin
         check({tag, "_ready_low_in_flush"}, 32'(bus.s_axis_product_tready), 0);
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 3);
      check({tag, "_index"}, 32'(bus.peak_index), 32'(exp_idx));
      check({tag, "_mag"}, 32'(bus.peak_mag), 32'(exp_mag));
   endtask

   task automatic handoff(input string tag);
      bus.m_axis_peak_tready = 1'b1;
      tick();
      bus.m_axis_peak_tready = 1'b0;
      check({tag, "_tvalid_after_handoff"}, 32'(bus.s_axis_peak_tvalid), 0);
      check({tag, "_ready_after_handoff"}, 32'(bus.s_axis_product_tready), 1);
   endtask

   initial begin
      bus.m_axis_product_tvalid = 1'b0;
      bus.i = '0;
      bus.q = '0;
      bus.m_axis_peak_tready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tvalid", 32'(bus.s_axis_peak_tvalid), 0);
      check("rst_tready", 32'(bus.s_axis_product_tready), 0);
      check("rst_index", 32'(bus.peak_index), 0);
      check("rst_mag", 32'(bus.peak_mag), 0);
      check("rst_state", 32'(dbg_state), 0);
      rst_n = 1'b1;
      tick();
      check("ready_after_release", 32'(bus.s_axis_product_tready), 1);

      // Basic frame, back-to-back: mags 1,25,4,5
      send(1, 0, 0); send(3, 4, 0); send(0, 2, 0); send(-2, -1, 0);
      expect_peak("basic", 1, 25);
      handoff("basic");

      // Tie keeps earliest: mags 25,25,25,1
      send(3, 4, 0); send(5, 0, 0); send(4, 3, 0); send(0, 1, 0);
      expect_peak("tie", 0, 25);
      handoff("tie");

      // Extreme negative: 2 * 128^2
      send(0, 0, 0); send(0, 0, 0); send(0, 0, 0); send(-128, -128, 0);
      expect_peak("extreme", 3, 32768);
      handoff("extreme");

      // Backpressure: mags 4,0,2,9; upstream keeps (5,5) valid while peak is held
      send(2, 0, 0); send(0, 0, 0); send(1, 1, 0); send(0, 3, 0);
      expect_peak("bp", 3, 9);
      bus.i = IB'(5);
      bus.q = IB'(5);
      bus.m_axis_product_tvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold_tvalid", 32'(bus.s_axis_peak_tvalid), 1);
         check("bp_hold_tready", 32'(bus.s_axis_product_tready), 0);
         check("bp_hold_index", 32'(bus.peak_index), 3);
         check("bp_hold_mag", 32'(bus.peak_mag), 9);
         check("bp_hold_state", 32'(dbg_state), 2);
      end
      bus.m_axis_peak_tready = 1'b1;
      tick();
      bus.m_axis_peak_tready = 1'b0;
      check("bp_tvalid_after_handoff", 32'(bus.s_axis_peak_tvalid), 0);
      check("bp_ready_after_handoff", 32'(bus.s_axis_product_tready), 1);
      // The still-valid (5,5) is taken now as index 0 of the next frame (mag 50)
      tick();
      bus.m_axis_product_tvalid = 1'b0;
      send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
      expect_peak("bp_next", 0, 50);
      handoff("bp_next");

      // Gapped valids, 1 on / 2 off: mags 1,0,49,9
      send(0, 1, 2); send(0, 0, 2); send(7, 0, 2); send(0, 3, 0);
      expect_peak("gapped", 2, 49);
      handoff("gapped");

      // Reset mid-frame after two accepts (best already holds 162)
      send(9, 9, 0); send(9, 9, 0);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("midrst_tvalid", 32'(bus.s_axis_peak_tvalid), 0);
      check("midrst_tready", 32'(bus.s_axis_product_tready), 0);
      check("midrst_index", 32'(bus.peak_index), 0);
      check("midrst_mag", 32'(bus.peak_mag), 0);
      check("midrst_state", 32'(dbg_state), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_ready_after_release", 32'(bus.s_axis_product_tready), 1);
      send(2, 2, 0); send(0, 0, 0); send(0, 0, 0); send(1, 1, 0);
      expect_peak("after_rst", 0, 8);
      handoff("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
